// File: rtl/stopwatch_digits_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Purpose  : Shared types, constants and the BCD increment helper for the
//            stopwatch_digits block.
// Contents : sw_state_t  - run/pause/clear state encoding
//            BCD_MAX     - largest legal value of a decimal digit
//            DIGITS      - number of BCD digits in the count
//            bcd_inc()   - ripple-carry BCD increment, returns {carry, value}
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int         DIGITS  = 4;

    // The carry out of the top digit is the 9999 -> 0000 roll-over flag.
    // Digits at or above BCD_MAX roll to 0, so a digit can never leave 0..9.
    function automatic logic [4*DIGITS:0] bcd_inc(input logic [4*DIGITS-1:0] value);
        logic [4*DIGITS-1:0] next_value;
        logic                carry;
        next_value = value;
        carry      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (value[4*i +: 4] >= BCD_MAX) begin
                    next_value[4*i +: 4] = 4'd0;
                end else begin
                    next_value[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry                = 1'b0;
                end
            end
        end
        return {carry, next_value};
    endfunction

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/stopwatch_digits_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : key_conditioner
// Purpose  : Conditions one raw active-low push-button: 2-flop synchronizer,
//            consecutive-cycle debounce, and a one-cycle press pulse on the
//            debounced 1->0 transition (releases produce nothing).
// Ports    : CLOCK_50 - system clock, rising edge
//            RESET_N  - asynchronous active-low reset
//            KEY_N    - raw button level, asynchronous to CLOCK_50
//            PRESS    - one-cycle press event
// Params   : DB_CYCLES - stable cycles needed before a new level is accepted
// Revision : 1.0 - initial release
// ============================================================================
module key_conditioner
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic KEY_N,
    output logic PRESS
);

    localparam int                 c_CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;

    // The counter only advances while the synchronized value disagrees with
    // the accepted level, so any bounce back to the old level restarts it.
    // The press pulse is registered alongside the level update, which puts
    // it DB_CYCLES+2 cycles after the raw edge.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= KEY_N;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                // Old level high means this is a 1->0 (press) transition.
                r_press <= r_level;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign PRESS = r_press;

endmodule : key_conditioner
`default_nettype wire

// File: rtl/stopwatch_digits.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_digits
// Purpose  : Prescaled 4-digit BCD stopwatch with run/pause/clear buttons,
//            feeding one nibble per 7-segment digit (D0 least significant).
// Ports    : CLOCK_50   - system clock, rising edge
//            RESET_N    - asynchronous active-low reset
//            START_STOP - raw active-low start/stop button
//            CLEAR      - raw active-low clear button
//            LAP        - raw active-low lap button (STOPWATCH_LAP_EN only)
//            D0..D3     - BCD digits, always 0..9
//            RUNNING    - high while in RUN
//            WRAP       - one-cycle pulse on 9999 -> 0000
// Params   : TICK_DIV  - clock cycles per count increment
//            DB_CYCLES - button debounce length in cycles
// Macro    : STOPWATCH_LAP_EN - adds LAP button and a display hold register
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_digits
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 5000000,
    parameter int DB_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       START_STOP,
    input  logic       CLEAR,
`ifdef STOPWATCH_LAP_EN
    input  logic       LAP,
`endif
    output logic [3:0] D0,
    output logic [3:0] D1,
    output logic [3:0] D2,
    output logic [3:0] D3,
    output logic       RUNNING,
    output logic       WRAP
);

    localparam int                 c_PRE_W    = $clog2(TICK_DIV);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);
    localparam int                 c_CNT_W    = 4 * DIGITS;

    logic                 w_start_ev;
    logic                 w_clear_ev;
    logic                 w_tick;
    logic [c_CNT_W:0]     w_inc;
    logic [c_CNT_W-1:0]   w_disp;
    sw_state_t            w_state_nxt;

    sw_state_t            r_state;
    logic [c_PRE_W-1:0]   r_pre;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_running;
    logic                 r_wrap;

    key_conditioner #(.DB_CYCLES(DB_CYCLES)) u_key_start (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .KEY_N    (START_STOP),
        .PRESS    (w_start_ev)
    );

    key_conditioner #(.DB_CYCLES(DB_CYCLES)) u_key_clear (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .KEY_N    (CLEAR),
        .PRESS    (w_clear_ev)
    );

    // Clear has priority over a coincident start/stop event.
    always_comb begin
        w_state_nxt = r_state;
        if (w_clear_ev) begin
            w_state_nxt = IDLE;
        end else if (w_start_ev) begin
            case (r_state)
                IDLE:    w_state_nxt = RUN;
                RUN:     w_state_nxt = PAUSE;
                PAUSE:   w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_tick = (r_state == RUN) && (r_pre == c_PRE_LAST);
    assign w_inc  = bcd_inc(r_count);

    // The prescaler only moves in RUN, so PAUSE keeps the sub-tick phase.
    // RUNNING is registered from the next state so it rises together with
    // the state register rather than one cycle later.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= IDLE;
            r_pre     <= '0;
            r_count   <= '0;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == RUN);
            r_wrap    <= 1'b0;
            if (w_clear_ev) begin
                r_pre   <= '0;
                r_count <= '0;
            end else if (r_state == RUN) begin
                if (w_tick) begin
                    r_pre   <= '0;
                    r_count <= w_inc[c_CNT_W-1:0];
                    r_wrap  <= w_inc[c_CNT_W];
                end else begin
                    r_pre <= r_pre + c_PRE_W'(1);
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic               w_lap_ev;
    logic               r_hold;
    logic [c_CNT_W-1:0] r_lap;

    key_conditioner #(.DB_CYCLES(DB_CYCLES)) u_key_lap (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .KEY_N    (LAP),
        .PRESS    (w_lap_ev)
    );

    // Capture takes the pre-tick count, which is what the display shows in
    // that cycle, so a lap coincident with a tick freezes the visible value.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hold <= 1'b0;
            r_lap  <= '0;
        end else if (w_clear_ev) begin
            r_hold <= 1'b0;
        end else if (w_lap_ev) begin
            if (r_state == RUN) begin
                r_hold <= ~r_hold;
                if (!r_hold) begin
                    r_lap <= r_count;
                end
            end else begin
                r_hold <= 1'b0;
            end
        end
    end

    assign w_disp = r_hold ? r_lap : r_count;
`else
    assign w_disp = r_count;
`endif

    assign D0      = w_disp[3:0];
    assign D1      = w_disp[7:4];
    assign D2      = w_disp[11:8];
    assign D3      = w_disp[15:12];
    assign RUNNING = r_running;
    assign WRAP    = r_wrap;

endmodule : stopwatch_digits
`default_nettype wire

// File: tb/tb_stopwatch_digits.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_digits
// Purpose  : Directed self-checking bench for stopwatch_digits with
//            TICK_DIV=4 and DB_CYCLES=3. Expected digit values are queued
//            when a stimulus step is driven and popped when sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_digits;

    localparam int TICK_DIV  = 4;
    localparam int DB_CYCLES = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_n;
    logic       clear_n;
    logic [3:0] d0, d1, d2, d3;
    logic       running;
    logic       wrap;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    stopwatch_digits #(
        .TICK_DIV  (TICK_DIV),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .START_STOP (start_n),
        .CLEAR      (clear_n),
`ifdef STOPWATCH_LAP_EN
        .LAP        (1'b1),
`endif
        .D0         (d0),
        .D1         (d1),
        .D2         (d2),
        .D3         (d3),
        .RUNNING    (running),
        .WRAP       (wrap)
    );

    // All driving and sampling happens on falling edges, away from the
    // active edge; step(n) advances across n rising edges.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_digits(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: observed %h, expected <none queued>", tag, {d3, d2, d1, d0});
        end else begin
            e = exp_q.pop_front();
            chk(tag, {d3, d2, d1, d0}, e);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic expv);
        chk(tag, {15'd0, obs}, {15'd0, expv});
    endtask

    initial begin
        rst_n   = 1'b0;
        start_n = 1'b1;
        clear_n = 1'b1;

        // Reset held for two cycles.
        exp_q.push_back(16'h0000);
        step(2);
        chk_digits("reset_digits");
        chk_bit("reset_running", running, 1'b0);
        chk_bit("reset_wrap", wrap, 1'b0);
        rst_n = 1'b1;
        step(2);

        // Start: RUNNING at edge 6, first increment 4 edges later, 0010 after 40.
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0010);
        start_n = 1'b0;
        step(5);
        chk_bit("start_running_early", running, 1'b0);
        step(1);
        chk_bit("start_running", running, 1'b1);
        step(3);
        chk_digits("start_before_tick");
        step(1);
        chk_digits("start_first_tick");
        start_n = 1'b1;
        step(36);
        chk_digits("start_forty_cycles");

        // Pause: event lands with count 0011 and prescaler at 2.
        exp_q.push_back(16'h0011);
        exp_q.push_back(16'h0011);
        start_n = 1'b0;
        step(5);
        chk_bit("pause_running_early", running, 1'b1);
        step(1);
        chk_bit("pause_running", running, 1'b0);
        chk_digits("pause_stop");
        start_n = 1'b1;
        step(100);
        chk_digits("pause_hold_100");
        chk_bit("pause_still_stopped", running, 1'b0);

        // Resume keeps the prescaler phase: next digit 2 cycles after RUNNING.
        exp_q.push_back(16'h0011);
        exp_q.push_back(16'h0012);
        start_n = 1'b0;
        step(5);
        chk_bit("resume_running_early", running, 1'b0);
        step(1);
        chk_bit("resume_running", running, 1'b1);
        chk_digits("resume_at_rise");
        start_n = 1'b1;
        step(2);
        chk_digits("resume_next_tick");
        step(10);

        // Bouncy press never stable for 3 cycles: no event.
        start_n = 1'b0;
        step(2);
        start_n = 1'b1;
        step(1);
        start_n = 1'b0;
        step(2);
        start_n = 1'b1;
        step(12);
        chk_bit("bounce_no_event", running, 1'b1);

        // One-cycle glitch restarts the debounce: event shifts by 3 cycles.
        start_n = 1'b0;
        step(2);
        start_n = 1'b1;
        step(1);
        start_n = 1'b0;
        step(5);
        chk_bit("glitch_not_yet", running, 1'b1);
        step(1);
        chk_bit("glitch_paused", running, 1'b0);
        start_n = 1'b1;
        step(10);

        // Back to RUN, then start and clear events in the same cycle.
        start_n = 1'b0;
        step(6);
        chk_bit("rerun_running", running, 1'b1);
        start_n = 1'b1;
        step(10);
        exp_q.push_back(16'h0000);
        start_n = 1'b0;
        clear_n = 1'b0;
        step(5);
        chk_bit("clear_running_early", running, 1'b1);
        step(1);
        chk_bit("clear_wins_running", running, 1'b0);
        chk_digits("clear_wins_digits");
        chk_bit("clear_wins_wrap", wrap, 1'b0);
        start_n = 1'b1;
        clear_n = 1'b1;
        step(10);

        // Restart from IDLE (prescaler was cleared) and run through 9999.
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h9999);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0042);
        start_n = 1'b0;
        step(6);
        chk_bit("restart_running", running, 1'b1);
        start_n = 1'b1;
        step(3);
        chk_digits("restart_before_tick");
        step(1);
        chk_digits("restart_first_tick");
        step(39995);
        chk_digits("wrap_at_9999");
        chk_bit("wrap_low_before", wrap, 1'b0);
        step(1);
        chk_digits("wrap_rollover");
        chk_bit("wrap_pulse", wrap, 1'b1);
        chk_bit("wrap_still_running", running, 1'b1);
        step(1);
        chk_digits("wrap_after");
        chk_bit("wrap_one_cycle", wrap, 1'b0);
        step(167);
        chk_digits("count_0042");

        // Asynchronous reset mid-count, checked before the next rising edge.
        exp_q.push_back(16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk_digits("async_reset_digits");
        chk_bit("async_reset_running", running, 1'b0);
        chk_bit("async_reset_wrap", wrap, 1'b0);
        step(2);
        rst_n = 1'b1;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_stopwatch_digits
`default_nettype wire

// File: doc/stopwatch_digits.md
Name: stopwatch_digits

Overview:
- Upstream digit source for the four hexdisplay instances on the board.
- Conditions two push-buttons: START_STOP and CLEAR, both active-low.
- Runs a prescaled 4-digit BCD up-counter with run/pause/clear control.
- Presents one 4-bit nibble per 7-segment digit (D0 least significant). D3..D0 wire straight into hexdisplay I inputs; each digit is always in the range 0..9.

Parameters:
- TICK_DIV, 5000000, CLOCK_50 cycles per count increment (default gives 0.1 s at 50 MHz); legal range 2..2^26.
- DB_CYCLES, 500000, consecutive stable synchronized cycles required before a button level is accepted; legal range 1..2^20.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- START_STOP  in  1  raw active-low push-button, asynchronous to CLOCK_50
- CLEAR  in  1  raw active-low push-button, asynchronous to CLOCK_50
- D0  out  4  BCD units digit
- D1  out  4  BCD tens digit
- D2  out  4  BCD hundreds digit
- D3  out  4  BCD thousands digit
- RUNNING  out  1  high while state is RUN
- WRAP  out  1  one-cycle pulse when the count rolls 9999 -> 0000

Behaviour:
- Reset: asserting RESET_N low takes effect asynchronously, at any time, including mid-count.
  - Outputs: D0..D3 = 0, RUNNING = 0, WRAP = 0.
  - Internal: state IDLE, prescaler = 0, synchronizers and debounced levels = 1 (released), debounce counters = 0.
- Button conditioning, per button:
  - 2-flop synchronizer.
  - Debounce: the debounced level takes the synchronized value once that value has differed from it for DB_CYCLES consecutive cycles. Any bounce restarts the count.
  - A press event is a one-cycle pulse on a debounced 1->0 transition. Releases generate no event.
- Event latency: press event fires DB_CYCLES+2 cycles after the raw falling edge. State/output registers update on the following edge.
- FSM states IDLE, RUN, PAUSE. Transitions:
  - IDLE + start_ev -> RUN
  - RUN + start_ev -> PAUSE
  - PAUSE + start_ev -> RUN
  - any state + clear_ev -> IDLE, with digits = 0 and prescaler = 0
  - start_ev and clear_ev in the same cycle: clear wins, result is IDLE
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; tick asserts when it equals TICK_DIV-1, and it then returns to 0.
  - In PAUSE it holds its value, so resume preserves sub-tick phase.
  - First tick after IDLE->RUN occurs TICK_DIV cycles after entering RUN.
- BCD increment on tick:
  - D0 increments; at 9 it goes to 0 and carries into D1, rippling the same way through D3.
  - 9999 -> 0000 in the same cycle; WRAP = 1 for exactly that cycle; the counter stays in RUN.
  - No digit ever holds 10..15.
- Outputs are registered. D0..D3 change on the clock edge after the tick cycle. RUNNING is registered from the state.
- clear_ev coincident with tick: clear wins; digits become 0 and WRAP stays 0.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- When defined:
  - Adds input port LAP (raw active-low), conditioned identically to the other buttons.
  - lap_ev in RUN toggles a hold flag. While held, D0..D3 freeze at the value captured on lap_ev and the internal count continues. WRAP still pulses from the internal count.
  - lap_ev in IDLE/PAUSE releases the hold.
  - clear_ev releases the hold.
  - Release makes D0..D3 show the live count on the next edge.
- When undefined: no LAP port, no hold register; D0..D3 are the live count registers.

Decomposition:
- Package stopwatch_pkg:
  - state enum sw_state_t {IDLE, RUN, PAUSE}
  - BCD_MAX = 4'd9
  - DIGITS = 4
- Sub-module key_conditioner (parameter DB_CYCLES; ports CLOCK_50, RESET_N, KEY_N, PRESS): synchronizer, debounce and falling-edge pulse.
  - Instantiated once per button, three times with STOPWATCH_LAP_EN.

Test Plan (TICK_DIV=4, DB_CYCLES=3):
- Reset: RESET_N low for 2 cycles, then high -> D3..D0 = 0000, RUNNING = 0, WRAP = 0. Asserting RESET_N mid-run at count 0042 clears everything asynchronously before the next edge.
- Start: START_STOP held low 10 cycles -> RUNNING rises 6 cycles after the falling edge. Digits read 0001 after 4 further cycles and 0010 after 40 cycles of RUN.
- Debounce: START_STOP low 2 cycles, high 1, low 2, high -> no state change. A 1-cycle glitch inside a valid press delays the event by the glitch restart.
- Pause/resume: stop at count 0007 with prescaler 2 -> digits hold 0007 for 100 cycles. Resume -> 0008 appears 2 cycles after RUNNING rises.
- Wrap: force/run to 9999, next tick -> 0000 and WRAP high for exactly 1 cycle; RUNNING stays 1.
- Clear priority: START_STOP and CLEAR released/pressed so both events fire in the same cycle while running at 0123 -> IDLE, 0000, RUNNING = 0. With STOPWATCH_LAP_EN: lap at 0050, run 20 cycles -> outputs stay 0050; second lap -> outputs show 0055.
